fnd_scan_ctrl: RTL and testbench

- Drives the board's 4-digit multiplexed 7-segment display (FND) from the 4-bit adder result.
- Sits directly downstream of the adder. Top level ties value_in = {c, sum}, a 5-bit value in the range 0..31.
- Divides the system clock into a scan tick, rotates the active digit on each tick, snapshots the input once per full scan, converts it to decimal digits and drives active-low segment and common lines.

---
 rtl/fnd_pkg.sv | 41 ++++
 rtl/fnd_bcd_decoder.sv | 11 +
 rtl/fnd_scan_ctrl.sv | 119 +++++++++++
 tb/tb_fnd_scan_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants and the digit-to-segment mapping for the 4-digit FND scanner.
// Segments are active-low, ordered {dp,g,f,e,d,c,b,a}; commons are active-low.
package fnd_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] COM_OFF   = 4'b1111;

  typedef logic [1:0] digit_sel_t;

  // Codes 10..15 are not decimal digits and render dark.
  function automatic logic [7:0] seg_of(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] com_of(input digit_sel_t sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/fnd_bcd_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern (dp held off).
module fnd_bcd_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [7:0] o_seg
);

  assign o_seg = seg_of(i_digit);

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 4-digit FND scanner: divides clk into digit slots, snapshots the
// input once per full scan and drives registered active-low commons/segments.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int DATA_W   = 5,
  parameter int TICK_DIV = 100_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              blank_en,
  input  logic [DATA_W-1:0] value_in,
  output logic [3:0]        fnd_com,
  output logic [7:0]        fnd_data,
  output logic              scan_tick
);

  localparam int               CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0]  r_tick_cnt;
  digit_sel_t        r_digit_sel;
  logic [DATA_W-1:0] r_shadow;
  logic [3:0]        r_fnd_com;
  logic [7:0]        r_fnd_data;
  logic              r_scan_tick;

  logic              w_tick_last;
  digit_sel_t        w_next_sel;
  logic              w_wrap;
  logic [DATA_W-1:0] w_value;
  logic [13:0]       w_v14;
  logic [3:0]        w_d0, w_d1, w_d2, w_d3;
  logic [3:0]        w_digit;
  logic              w_blank;
  logic [7:0]        w_seg;

  assign w_tick_last = (r_tick_cnt == TICK_LAST);
  assign w_next_sel  = r_digit_sel + 2'd1;
  assign w_wrap      = (w_next_sel == 2'd0);

  // Digit 0 of a new scan reads value_in directly so the whole scan shows the
  // same sample that is being captured into r_shadow on this edge.
  assign w_value = w_wrap ? value_in : r_shadow;
  assign w_v14   = 14'(w_value);

  assign w_d0 = 4'(w_v14 % 14'd10);
  assign w_d1 = 4'((w_v14 / 14'd10) % 14'd10);
  assign w_d2 = 4'((w_v14 / 14'd100) % 14'd10);
  assign w_d3 = 4'(w_v14 / 14'd1000);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_digit = w_d0;
    w_blank = 1'b0;
    case (w_next_sel)
      2'd1: begin
        w_digit = w_d1;
        w_blank = blank_en && (w_d1 == 4'd0) && (w_d2 == 4'd0) && (w_d3 == 4'd0);
      end
      2'd2: begin
        w_digit = w_d2;
        w_blank = blank_en && (w_d2 == 4'd0) && (w_d3 == 4'd0);
      end
      2'd3: begin
        w_digit = w_d3;
        w_blank = blank_en && (w_d3 == 4'd0);
      end
      default: begin
        w_digit = w_d0;
        w_blank = 1'b0;
      end
    endcase
  end

  fnd_bcd_decoder u_bcd_decoder (
    .i_digit (w_digit),
    .o_seg   (w_seg)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick_cnt  <= '0;
      r_digit_sel <= 2'd3;
      r_shadow    <= '0;
      r_fnd_com   <= COM_OFF;
      r_fnd_data  <= SEG_BLANK;
      r_scan_tick <= 1'b0;
    end else begin
      r_scan_tick <= w_tick_last;
      if (w_tick_last) begin
        r_tick_cnt  <= '0;
        r_digit_sel <= w_next_sel;
        if (w_wrap) begin
          r_shadow <= value_in;
        end
        if (en) begin
          r_fnd_com  <= com_of(w_next_sel);
          r_fnd_data <= w_blank ? SEG_BLANK : w_seg;
        end else begin
          r_fnd_com  <= COM_OFF;
          r_fnd_data <= SEG_BLANK;
        end
      end else begin
        r_tick_cnt <= r_tick_cnt + CNT_ONE;
      end
    end
  end

  assign fnd_com   = r_fnd_com;
  assign fnd_data  = r_fnd_data;
  assign scan_tick = r_scan_tick;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl (TICK_DIV=4, DATA_W=5): directed scenarios
// plus randomized traffic against a cycle-level arithmetic model of the display.
module tb_fnd_scan_ctrl;

  localparam int DATA_W   = 5;
  localparam int TICK_DIV = 4;

  localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                         8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  localparam logic [3:0] COM_SEQ [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b1;
  logic              blank_en = 1'b0;
  logic [DATA_W-1:0] value_in = '0;
  logic [3:0]        fnd_com;
  logic [7:0]        fnd_data;
  logic              scan_tick;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: edges since reset release, the scan sample and expected outputs.
  int         m_k      = 0;
  int         m_dig    = 3;
  int         m_sample = 0;
  logic [3:0] m_com    = 4'hF;
  logic [7:0] m_data   = 8'hFF;
  logic       m_tick   = 1'b0;

  fnd_scan_ctrl #(.DATA_W(DATA_W), .TICK_DIV(TICK_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .blank_en  (blank_en),
    .value_in  (value_in),
    .fnd_com   (fnd_com),
    .fnd_data  (fnd_data),
    .scan_tick (scan_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_seg(input int v, input int dig, input logic blank);
    int p = 1;
    for (int i = 0; i < dig; i++) p = p * 10;
    if (blank && dig > 0 && v < p) return 8'hFF;
    return SEG_TAB[(v / p) % 10];
  endfunction

  // Advance one clock: update the model at the edge, return at the falling edge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      m_k    = 0;
      m_dig  = 3;
      m_com  = 4'hF;
      m_data = 8'hFF;
      m_tick = 1'b0;
    end else begin
      m_k++;
      m_tick = (m_k % TICK_DIV == 0);
      if (m_tick) begin
        m_dig = ((m_k / TICK_DIV) - 1) % 4;
        if (m_dig == 0) m_sample = int'(value_in);
        if (en) begin
          m_com  = COM_SEQ[m_dig];
          m_data = exp_seg(m_sample, m_dig, blank_en);
        end else begin
          m_com  = 4'hF;
          m_data = 8'hFF;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_tick();
    do step(); while (!m_tick);
  endtask

  task automatic wait_digit(input int d);
    do wait_tick(); while (m_dig != d);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; blank_en = 1'b0; value_in = 5'd31;
    repeat (3) step();
    n_total++;
    if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF || scan_tick !== 1'b0)
      $display("FAIL reset_state: com=%b data=%h tick=%b want 1111/ff/0", fnd_com, fnd_data, scan_tick);
    else n_pass++;
    rst_n = 1'b1;
    for (int i = 1; i <= TICK_DIV; i++) begin
      step();
      n_total++;
      if (scan_tick !== (i == TICK_DIV))
        $display("FAIL first_tick cyc%0d: tick=%b want %b", i, scan_tick, (i == TICK_DIV));
      else n_pass++;
    end
    n_total++;
    if (fnd_com !== 4'b1110 || fnd_data !== 8'hF9)
      $display("FAIL first_digit: com=%b data=%h want 1110/f9", fnd_com, fnd_data);
    else n_pass++;
  endtask

  task automatic test_scan31();
    logic [7:0] want [2][4] = '{'{8'hF9, 8'hB0, 8'hC0, 8'hC0}, '{8'hF9, 8'hB0, 8'hFF, 8'hFF}};
    value_in = 5'd31; en = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      blank_en = (pass == 1);
      wait_digit(0);
      for (int d = 0; d < 4; d++) begin
        if (d > 0) wait_tick();
        n_total++;
        if (fnd_com !== COM_SEQ[d] || fnd_data !== want[pass][d])
          $display("FAIL scan31 blank=%0d d%0d: com=%b data=%h want %b/%h",
                   pass, d, fnd_com, fnd_data, COM_SEQ[d], want[pass][d]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_snapshot();
    logic [7:0] want [6] = '{8'hF8, 8'hC0, 8'hC0, 8'hC0, 8'hA4, 8'hF9};
    value_in = 5'd7; blank_en = 1'b0; en = 1'b1;
    wait_digit(0);
    for (int s = 0; s < 6; s++) begin
      if (s > 0) wait_tick();
      n_total++;
      if (fnd_com !== COM_SEQ[s % 4] || fnd_data !== want[s])
        $display("FAIL snapshot slot%0d: com=%b data=%h want %b/%h",
                 s, fnd_com, fnd_data, COM_SEQ[s % 4], want[s]);
      else n_pass++;
      if (s == 1) value_in = 5'd12;
    end
  endtask

  task automatic test_zero_blank();
    logic [7:0] want [4] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
    value_in = 5'd0; blank_en = 1'b1; en = 1'b1;
    wait_digit(0);
    for (int d = 0; d < 4; d++) begin
      if (d > 0) wait_tick();
      n_total++;
      if (fnd_com !== COM_SEQ[d] || fnd_data !== want[d])
        $display("FAIL zero_blank d%0d: com=%b data=%h want %b/%h",
                 d, fnd_com, fnd_data, COM_SEQ[d], want[d]);
      else n_pass++;
    end
  endtask

  task automatic test_enable();
    value_in = 5'd31; blank_en = 1'b0; en = 1'b1;
    wait_digit(1);
    step();
    en = 1'b0;
    wait_tick();
    n_total++;
    if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF || scan_tick !== 1'b1)
      $display("FAIL en_off: com=%b data=%h tick=%b want 1111/ff/1", fnd_com, fnd_data, scan_tick);
    else n_pass++;
    for (int i = 1; i <= TICK_DIV; i++) begin
      step();
      n_total++;
      if (scan_tick !== (i == TICK_DIV) || fnd_com !== 4'b1111 || fnd_data !== 8'hFF)
        $display("FAIL en_off_run cyc%0d: com=%b data=%h tick=%b want 1111/ff/%b",
                 i, fnd_com, fnd_data, scan_tick, (i == TICK_DIV));
      else n_pass++;
    end
    en = 1'b1;
    wait_tick();
    n_total++;
    if (fnd_com !== 4'b1110 || fnd_data !== 8'hF9)
      $display("FAIL en_resume: com=%b data=%h want 1110/f9", fnd_com, fnd_data);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    value_in = 5'd31; blank_en = 1'b0; en = 1'b1;
    wait_digit(2);
    step();
    rst_n = 1'b0;
    step();
    n_total++;
    if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF || scan_tick !== 1'b0)
      $display("FAIL reset_mid: com=%b data=%h tick=%b want 1111/ff/0", fnd_com, fnd_data, scan_tick);
    else n_pass++;
    rst_n = 1'b1;
    value_in = 5'd19;
    for (int i = 1; i <= TICK_DIV; i++) begin
      step();
      n_total++;
      if (scan_tick !== (i == TICK_DIV))
        $display("FAIL restart_tick cyc%0d: tick=%b want %b", i, scan_tick, (i == TICK_DIV));
      else n_pass++;
    end
    n_total++;
    if (fnd_com !== 4'b1110 || fnd_data !== 8'h90)
      $display("FAIL restart_d0: com=%b data=%h want 1110/90", fnd_com, fnd_data);
    else n_pass++;
    wait_tick();
    n_total++;
    if (fnd_com !== 4'b1101 || fnd_data !== 8'hF9)
      $display("FAIL restart_d1: com=%b data=%h want 1101/f9", fnd_com, fnd_data);
    else n_pass++;
  endtask

  // Reset asserted on the very edge that would have ticked must still win.
  task automatic test_reset_priority();
    value_in = 5'd23; en = 1'b1;
    wait_tick();
    repeat (TICK_DIV - 1) step();
    rst_n = 1'b0;
    step();
    n_total++;
    if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF || scan_tick !== 1'b0)
      $display("FAIL reset_priority: com=%b data=%h tick=%b want 1111/ff/0", fnd_com, fnd_data, scan_tick);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) value_in = DATA_W'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) blank_en = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 199) != 0);
      step();
      n_total++;
      if (fnd_com !== m_com || fnd_data !== m_data || scan_tick !== m_tick)
        $display("FAIL random cyc%0d: com=%b data=%h tick=%b want %b/%h/%b",
                 c, fnd_com, fnd_data, scan_tick, m_com, m_data, m_tick);
      else n_pass++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan31();
    test_snapshot();
    test_zero_blank();
    test_enable();
    test_reset_mid();
    test_reset_priority();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
